// File: rtl/wstorage_sched_pkg.sv
// Shared definitions for the twiddle-ROM address sequencer: default geometry,
// derived butterfly count, inverse-table base and the FSM state encoding.
package wstorage_sched_pkg;

  localparam int DEF_RING_DEPTH = 10;
  localparam int DEF_PE_DEPTH   = 5;
  localparam int DEF_HLEN       = 9;
  localparam int DEF_STAGE_GAP  = 4;

  // Butterflies per stage handled by one PE group.
  function automatic int bfly_per_stage(input int ring_depth, input int pe_depth);
    return 1 << (ring_depth - pe_depth - 1);
  endfunction

  localparam int DEF_C        = bfly_per_stage(DEF_RING_DEPTH, DEF_PE_DEPTH);
  localparam int DEF_INV_BASE = DEF_RING_DEPTH * DEF_C;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_GAP   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/wstorage_sched_if.sv
// Bundle between the polynomial controller / datapath (master) and the
// twiddle address sequencer (slave).
//
// Handshake: start is a one-cycle request honoured only while the sequencer is
// idle (busy=0); inverse is sampled with it. busy rises the cycle after start
// is accepted and falls after the one-cycle done pulse. stall is a level
// backpressure that freezes sequencing without losing or repeating an address.
// issue marks raddr as a new fetch; w_valid/w_last/stage describe the ROM
// output one cycle later.
interface wstorage_sched_if #(
  parameter int HLEN = 9,
  parameter int SW   = 4
);
  logic            start;
  logic            inverse;
  logic            stall;
  logic [HLEN-1:0] raddr;
  logic            issue;
  logic            w_valid;
  logic            w_last;
  logic [SW-1:0]   stage;
  logic            busy;
  logic            done;

  modport master (
    output start, inverse, stall,
    input  raddr, issue, w_valid, w_last, stage, busy, done
  );

  modport slave (
    input  start, inverse, stall,
    output raddr, issue, w_valid, w_last, stage, busy, done
  );
endinterface

// File: rtl/wstorage_sched.sv
// Twiddle-ROM address sequencer for one PE group. Walks every NTT/INTT stage,
// issuing one ROM address per butterfly cycle, inserts a drain gap between
// stages and aligns valid/last/stage flags with the 1-cycle ROM read.
module wstorage_sched
  import wstorage_sched_pkg::*;
#(
  parameter int RING_DEPTH = DEF_RING_DEPTH,
  parameter int PE_DEPTH   = DEF_PE_DEPTH,
  parameter int HLEN       = DEF_HLEN,
  parameter int STAGE_GAP  = DEF_STAGE_GAP
) (
  input  logic   clk,
  input  logic   reset,
  wstorage_sched_if.slave bus,
  output state_t fsm_state
);

  localparam int CLOG     = RING_DEPTH - PE_DEPTH - 1;
  localparam int C        = bfly_per_stage(RING_DEPTH, PE_DEPTH);
  localparam int JW       = (CLOG > 0) ? CLOG : 1;
  localparam int SW       = (RING_DEPTH > 1) ? $clog2(RING_DEPTH) : 1;
  localparam int GW       = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int INV_BASE = RING_DEPTH * C;

  localparam logic [JW-1:0]   J_LAST   = JW'(C - 1);
  localparam logic [SW-1:0]   S_LAST   = SW'(RING_DEPTH - 1);
  localparam logic [GW-1:0]   GAP_LAST = GW'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);
  localparam logic [HLEN-1:0] INV_ADDR = HLEN'(INV_BASE);
  localparam logic [HLEN-1:0] C_ADDR   = HLEN'(C);

  // Both tables (forward then inverse) must fit in the ROM address space.
  if ((2 ** HLEN) < 2 * RING_DEPTH * C) begin : g_hlen_too_small
    $error("wstorage_sched: HLEN too small for 2*RING_DEPTH*C twiddles");
  end

  state_t          state;
  logic [SW-1:0]   s;
  logic [JW-1:0]   j;
  logic [GW-1:0]   gap_cnt;
  logic            inv_q;

  logic [HLEN-1:0] raddr_q;
  logic            issue_q;
  logic            w_valid_q;
  logic            w_last_q;
  logic [SW-1:0]   stage_q;
  logic            busy_q;
  logic            done_q;

  logic [HLEN-1:0] base;
  logic [HLEN-1:0] stage_base;
  logic [HLEN-1:0] addr_in_stage;
  logic [HLEN-1:0] addr_next_stage;
  logic            j_last;
  logic            s_last;

  // C is a power of two, so the stage offset is a plain shift.
  assign base            = inv_q ? INV_ADDR : '0;
  assign stage_base      = base + (HLEN'(s) << CLOG);
  assign addr_in_stage   = stage_base + HLEN'(j) + HLEN'(1);
  assign addr_next_stage = stage_base + C_ADDR;
  assign j_last          = (j == J_LAST);
  assign s_last          = (s == S_LAST);

  assign bus.raddr   = raddr_q;
  assign bus.issue   = issue_q;
  assign bus.w_valid = w_valid_q;
  assign bus.w_last  = w_last_q;
  assign bus.stage   = stage_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign fsm_state   = state;

  // Sequencer FSM with registered address/flag outputs; the flag pipeline
  // copies the issuing cycle's (issue, last, stage) so it lines up with dout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      s         <= '0;
      j         <= '0;
      gap_cnt   <= '0;
      inv_q     <= 1'b0;
      raddr_q   <= '0;
      issue_q   <= 1'b0;
      w_valid_q <= 1'b0;
      w_last_q  <= 1'b0;
      stage_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      w_valid_q <= issue_q;
      w_last_q  <= issue_q & j_last;
      if (issue_q) begin
        stage_q <= s;
      end
      done_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          issue_q <= 1'b0;
          if (bus.start) begin
            inv_q   <= bus.inverse;
            s       <= '0;
            j       <= '0;
            gap_cnt <= '0;
            raddr_q <= bus.inverse ? INV_ADDR : '0;
            issue_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (bus.stall) begin
            // The address shown this cycle is already fetched; hold the
            // pointer so the next advance lands on the following address.
            issue_q <= 1'b0;
          end else if (!j_last) begin
            raddr_q <= addr_in_stage;
            j       <= j + 1'b1;
            issue_q <= 1'b1;
          end else if (s_last) begin
            issue_q <= 1'b0;
            state   <= ST_FLUSH;
          end else if (STAGE_GAP == 0) begin
            s       <= s + 1'b1;
            j       <= '0;
            raddr_q <= addr_next_stage;
            issue_q <= 1'b1;
          end else begin
            issue_q <= 1'b0;
            gap_cnt <= '0;
            state   <= ST_GAP;
          end
        end

        ST_GAP: begin
          issue_q <= 1'b0;
          if (!bus.stall) begin
            if (gap_cnt == GAP_LAST) begin
              s       <= s + 1'b1;
              j       <= '0;
              raddr_q <= addr_next_stage;
              issue_q <= 1'b1;
              state   <= ST_RUN;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end

        ST_FLUSH: begin
          // Final twiddle is on dout this cycle; done follows it.
          issue_q <= 1'b0;
          done_q  <= 1'b1;
          state   <= ST_DONE;
        end

        ST_DONE: begin
          issue_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= ST_IDLE;
        end

        default: begin
          issue_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wstorage_sched.sv
// Directed bench for wstorage_sched: forward/inverse runs, random stall,
// zero-gap variant, mid-run reset and ignored start requests.
module tb_wstorage_sched;
  import wstorage_sched_pkg::*;

  localparam int HLEN = 9;
  localparam int SW   = 4;
  localparam int RD   = 10;
  localparam int C    = 16;
  localparam int NISS = RD * C;

  logic clk = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [HLEN-1:0] exp_q[$];
  bit mon_en  = 1'b0;
  bit mon0_en = 1'b0;
  int wv_idx  = 0;
  int wl_cnt  = 0;
  int idx0    = 0;

  state_t st4;
  state_t st0;

  wstorage_sched_if #(.HLEN(HLEN), .SW(SW)) bif();
  wstorage_sched_if #(.HLEN(HLEN), .SW(SW)) bif0();

  wstorage_sched #(.STAGE_GAP(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bif),
    .fsm_state (st4)
  );

  wstorage_sched #(.STAGE_GAP(0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bif0),
    .fsm_state (st0)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // issue expected in cycle k after the start edge, for stage gap g
  function automatic bit exp_issue(input int k, input int g);
    int p;
    p = C + g;
    if (k < 1 || k > RD * C + (RD - 1) * g) return 1'b0;
    return ((k - 1) % p) < C;
  endfunction

  // scoreboard: addresses, stage index and last flag on the gapped instance
  always @(negedge clk) begin
    logic [HLEN-1:0] e;
    if (mon_en) begin
      if (bif.issue) begin
        if (exp_q.size() == 0) check("addr_extra", 32'(bif.raddr), 32'hffff_ffff);
        else begin
          e = exp_q.pop_front();
          check("raddr", 32'(bif.raddr), 32'(e));
        end
      end
      if (bif.w_valid) begin
        check("stage", 32'(bif.stage), 32'(wv_idx / C));
        check("w_last", 32'(bif.w_last), 32'((wv_idx % C) == C - 1));
        wv_idx++;
        if (bif.w_last) wl_cnt++;
      end
    end
  end

  // address model for the zero-gap instance
  always @(negedge clk) begin
    if (mon0_en && bif0.issue) begin
      check("raddr0", 32'(bif0.raddr), 32'(idx0));
      idx0++;
    end
  end

  // driver: one run from start to done; lat = cycles from start edge to done
  task automatic run(input int which, input bit inv, input bit rnd_stall, input bit pat,
                     input bit poke_busy, output int lat, output int n_stall);
    int g;
    int base;
    logic d, is, wv, bz;
    g = (which == 0) ? 4 : 0;
    base = inv ? RD * C : 0;
    n_stall = 0;
    if (which == 0) begin
      for (int a = 0; a < NISS; a++) exp_q.push_back(HLEN'(base + a));
      wv_idx = 0;
      wl_cnt = 0;
      mon_en = 1'b1;
    end else begin
      idx0 = base;
      mon0_en = 1'b1;
    end
    @(negedge clk);
    if (which == 0) begin bif.start = 1'b1; bif.inverse = inv; end
    else begin bif0.start = 1'b1; bif0.inverse = inv; end
    @(negedge clk);
    bif.start = 1'b0;
    bif0.start = 1'b0;
    lat = 1;
    while (lat < 1000) begin
      d  = (which == 0) ? bif.done    : bif0.done;
      is = (which == 0) ? bif.issue   : bif0.issue;
      wv = (which == 0) ? bif.w_valid : bif0.w_valid;
      bz = (which == 0) ? bif.busy    : bif0.busy;
      check("busy", 32'(bz), 32'd1);
      if (pat) begin
        check("issue", 32'(is), 32'(exp_issue(lat, g)));
        check("w_valid", 32'(wv), 32'(exp_issue(lat - 1, g)));
      end
      if (d) break;
      if (rnd_stall) begin
        bif.stall = (lat <= 150) && ($urandom_range(0, 3) == 0);
        if (bif.stall) n_stall++;
      end
      if (which == 0) begin
        bif.start   = poke_busy && (lat == 50);
        bif.inverse = (poke_busy && (lat == 50)) ? ~inv : inv;
      end
      @(negedge clk);
      lat++;
    end
    bif.stall = 1'b0;
    bif.start = 1'b0;
  endtask

  task automatic end_checks();
    check("addr_left", 32'(exp_q.size()), 32'd0);
    check("wv_count", 32'(wv_idx), 32'(NISS));
    check("w_last_count", 32'(wl_cnt), 32'(RD));
    mon_en = 1'b0;
  endtask

  initial begin
    int lat, ns, dcnt;
    bif.start = 1'b0; bif.inverse = 1'b0; bif.stall = 1'b0;
    bif0.start = 1'b0; bif0.inverse = 1'b0; bif0.stall = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_raddr", 32'(bif.raddr), 32'd0);
    check("rst_issue", 32'(bif.issue), 32'd0);
    check("rst_w_valid", 32'(bif.w_valid), 32'd0);
    check("rst_w_last", 32'(bif.w_last), 32'd0);
    check("rst_stage", 32'(bif.stage), 32'd0);
    check("rst_busy", 32'(bif.busy), 32'd0);
    check("rst_done", 32'(bif.done), 32'd0);
    check("rst_state", 32'(st4), 32'(ST_IDLE));
    reset = 1'b0;

    // forward run, no stall
    run(0, 1'b0, 1'b0, 1'b1, 1'b0, lat, ns);
    check("fwd_latency", 32'(lat), 32'd198);
    end_checks();

    // inverse run: addresses 160..319
    run(0, 1'b1, 1'b0, 1'b1, 1'b0, lat, ns);
    check("inv_latency", 32'(lat), 32'd198);
    end_checks();

    // random stall in RUN and GAP
    run(0, 1'b0, 1'b1, 1'b0, 1'b0, lat, ns);
    check("stall_latency", 32'(lat), 32'(198 + ns));
    end_checks();

    // zero gap: back-to-back issues
    run(1, 1'b0, 1'b0, 1'b1, 1'b0, lat, ns);
    check("gap0_latency", 32'(lat), 32'd162);
    check("gap0_count", 32'(idx0), 32'(NISS));
    mon0_en = 1'b0;

    // reset in the middle of stage 3
    @(negedge clk);
    bif.start = 1'b1; bif.inverse = 1'b0;
    @(negedge clk);
    bif.start = 1'b0;
    repeat (64) @(negedge clk);
    check("mid_issue", 32'(bif.issue), 32'd1);
    check("mid_raddr", 32'(bif.raddr), 32'd52);
    reset = 1'b1;
    @(negedge clk);
    check("abort_raddr", 32'(bif.raddr), 32'd0);
    check("abort_issue", 32'(bif.issue), 32'd0);
    check("abort_w_valid", 32'(bif.w_valid), 32'd0);
    check("abort_w_last", 32'(bif.w_last), 32'd0);
    check("abort_stage", 32'(bif.stage), 32'd0);
    check("abort_busy", 32'(bif.busy), 32'd0);
    check("abort_done", 32'(bif.done), 32'd0);
    reset = 1'b0;
    dcnt = 0;
    repeat (250) begin
      @(negedge clk);
      if (bif.done || bif.issue) dcnt++;
    end
    check("abort_quiet", 32'(dcnt), 32'd0);
    run(0, 1'b0, 1'b0, 1'b1, 1'b0, lat, ns);
    check("restart_latency", 32'(lat), 32'd198);
    end_checks();

    // start while busy and on the done cycle is ignored
    run(0, 1'b0, 1'b0, 1'b1, 1'b1, lat, ns);
    check("busy_start_latency", 32'(lat), 32'd198);
    end_checks();
    bif.start = 1'b1; bif.inverse = 1'b1;
    @(negedge clk);
    bif.start = 1'b0; bif.inverse = 1'b0;
    check("done_start_busy", 32'(bif.busy), 32'd0);
    check("done_start_issue", 32'(bif.issue), 32'd0);
    @(negedge clk);
    check("done_start_busy2", 32'(bif.busy), 32'd0);
    check("done_start_issue2", 32'(bif.issue), 32'd0);
    check("done_start_state", 32'(st4), 32'(ST_IDLE));
    run(0, 1'b1, 1'b0, 1'b1, 1'b0, lat, ns);
    check("after_latency", 32'(lat), 32'd198);
    end_checks();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
